// File: rtl/wb_ic_pkg.sv
// Shared types and default address map for the single-master Wishbone interconnect.
// Slave index 0 occupies the least significant word of the packed map vectors.
package wb_ic_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  localparam int DEF_NUM_SLAVES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  localparam logic [DEF_NUM_SLAVES*WB_ADDR_W-1:0] DEF_SLAVE_BASE = {
    32'h2000_0000, 32'h1000_0000, 32'h0001_0000, 32'h0000_0000
  };

  localparam logic [DEF_NUM_SLAVES*WB_ADDR_W-1:0] DEF_SLAVE_MASK = {
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } wb_ic_state_e;

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational address decoder: masked compare against every slave window,
// reduced to a one-hot hit where the lowest matching index wins.
module wb_addr_decoder
  import wb_ic_pkg::*;
#(
  parameter int                                NUM_SLAVES = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES*WB_ADDR_W-1:0]   SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*WB_ADDR_W-1:0]   SLAVE_MASK = DEF_SLAVE_MASK
) (
  input  logic [WB_ADDR_W-1:0]  adr_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic                  miss_o
);

  logic [NUM_SLAVES-1:0] raw_hit;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_window
    assign raw_hit[gi] =
      (adr_i & SLAVE_MASK[gi*WB_ADDR_W +: WB_ADDR_W]) == SLAVE_BASE[gi*WB_ADDR_W +: WB_ADDR_W];
  end

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (raw_hit[i]) begin
        hit_o    = '0;
        hit_o[i] = 1'b1;
      end
    end
  end

  assign miss_o = ~|raw_hit;

endmodule

// File: rtl/wb_bus_interconnect.sv
// Single-master Wishbone classic interconnect: decodes, routes one transaction
// at a time to a slave, registers the response and flags unmapped/timed-out accesses.
module wb_bus_interconnect
  import wb_ic_pkg::*;
#(
  parameter int                              NUM_SLAVES     = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES*WB_ADDR_W-1:0] SLAVE_BASE     = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*WB_ADDR_W-1:0] SLAVE_MASK     = DEF_SLAVE_MASK,
  parameter int                              TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WB_ADDR_W-1:0]            m_adr_i,
  input  logic [WB_DATA_W-1:0]            m_dat_i,
  input  logic [WB_SEL_W-1:0]             m_sel_i,
  input  logic                            m_we_i,
  input  logic                            m_cyc_i,
  input  logic                            m_stb_i,
  output logic [WB_DATA_W-1:0]            m_dat_o,
  output logic                            m_ack_o,
  output logic                            m_err_o,
  output logic [WB_ADDR_W-1:0]            s_adr_o,
  output logic [WB_DATA_W-1:0]            s_dat_o,
  output logic [WB_SEL_W-1:0]             s_sel_o,
  output logic                            s_we_o,
  output logic [NUM_SLAVES-1:0]           s_cyc_o,
  output logic [NUM_SLAVES-1:0]           s_stb_o,
  input  logic [NUM_SLAVES*WB_DATA_W-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]           s_ack_i,
  input  logic [NUM_SLAVES-1:0]           s_err_i
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  wb_ic_state_e state_q, state_d;

  logic [NUM_SLAVES-1:0] slv_q, slv_d;
  logic [WB_ADDR_W-1:0]  adr_q, adr_d;
  logic [WB_DATA_W-1:0]  wdat_q, wdat_d;
  logic [WB_SEL_W-1:0]   bsel_q, bsel_d;
  logic                  we_q, we_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [WB_DATA_W-1:0]  rdat_q, rdat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic [NUM_SLAVES-1:0] dec_hit;
  logic                  dec_miss;

  wb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .adr_i  (m_adr_i),
    .hit_o  (dec_hit),
    .miss_o (dec_miss)
  );

  // Only the latched slave's data and handshakes are visible to the FSM.
  logic [WB_DATA_W-1:0] rd_masked [NUM_SLAVES];
  logic [WB_DATA_W-1:0] rd_mux;
  logic                 slv_ack;
  logic                 slv_err;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_rd_mask
    assign rd_masked[gi] = s_dat_i[gi*WB_DATA_W +: WB_DATA_W] & {WB_DATA_W{slv_q[gi]}};
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rd_mux = rd_mux | rd_masked[i];
    end
  end

  assign slv_ack = |(s_ack_i & slv_q);
  assign slv_err = |(s_err_i & slv_q);

  always_comb begin
    state_d = state_q;
    slv_d   = slv_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    bsel_d  = bsel_q;
    we_d    = we_q;
    timer_d = timer_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          if (dec_miss) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = BUSY;
            slv_d   = dec_hit;
            adr_d   = m_adr_i;
            wdat_d  = m_dat_i;
            bsel_d  = m_sel_i;
            we_d    = m_we_i;
            timer_d = '0;
          end
        end
      end

      BUSY: begin
        if (timer_q != TMR_MAX) begin
          timer_d = timer_q + TMR_ONE;
        end
        // Abort beats any response; slave error beats a same-cycle ack.
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (slv_err) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else if (slv_ack) begin
          state_d = RESP;
          ack_d   = 1'b1;
          rdat_d  = rd_mux;
        end else if (timer_q == TMR_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end

      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slv_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      bsel_q  <= '0;
      we_q    <= 1'b0;
      timer_q <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slv_q   <= slv_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      bsel_q  <= bsel_d;
      we_q    <= we_d;
      timer_q <= timer_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign m_dat_o = rdat_q;
  assign m_ack_o = ack_q;
  assign m_err_o = err_q;

  assign s_adr_o = adr_q;
  assign s_dat_o = wdat_q;
  assign s_sel_o = bsel_q;
  assign s_we_o  = we_q;
  assign s_cyc_o = (state_q == BUSY) ? slv_q : '0;
  assign s_stb_o = (state_q == BUSY) ? slv_q : '0;

endmodule
